// File: rtl/serial_mul_pkg.sv
// Shared types and constants for the bit-serial multiplier (serial_mul_hs).
package serial_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W = 8;

    // Bit counter must index 2W serial positions without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/serial_mac_cell.sv
// One bit-serial multiply-add cell: adds (or subtracts, when sub=1) a&b to the
// sum arriving from the next-higher cell, keeping its own carry/borrow.
module serial_mac_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    input  logic a,
    input  logic b,
    input  logic si,
    input  logic sub,
    output logic so
);

    logic sum_q, sum_d;
    logic carry_q, carry_d;
    logic pp_s, s_in_s, c_in_s;

    // Full adder / full subtractor; sync discards state left by the previous operation.
    always_comb begin
        pp_s   = a & b;
        s_in_s = sync ? 1'b0 : si;
        c_in_s = sync ? 1'b0 : carry_q;
        sum_d  = s_in_s ^ pp_s ^ c_in_s;
        if (sub) begin
            carry_d = (~s_in_s & (pp_s | c_in_s)) | (pp_s & c_in_s);
        end else begin
            carry_d = (s_in_s & pp_s) | (s_in_s & c_in_s) | (pp_s & c_in_s);
        end
    end

    // Cell state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign so = sum_q;

endmodule

// File: rtl/serial_mul_hs.sv
// Handshaked bit-serial multiplier: q = a*b over 2W serial cycles plus one drain cycle.
// Define SERIAL_MUL_SIGNED_EN for two's-complement operands.
module serial_mul_hs
    import serial_mul_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] q,
    output logic           busy
);

    localparam int            CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * W - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sync_q, sync_d;
    logic             rdy_en_q, rdy_en_d;
    logic [W-1:0]     a_sr_q, a_sr_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-2:0]   sr_q, sr_d;
    logic [2*W-1:0]   q_q, q_d;
    logic [W-1:0]     so_s;

    // Cell chain: cell W-1 is the top of the accumulator, cell 0 emits product bits.
    for (genvar i = 0; i < W; i++) begin : g_cell
        logic si_s;
        logic sub_s;
        if (i == W - 1) begin : g_msb
            assign si_s = 1'b0;
`ifdef SERIAL_MUL_SIGNED_EN
            assign sub_s = 1'b1;
`else
            assign sub_s = 1'b0;
`endif
        end else begin : g_low
            assign si_s  = so_s[i+1];
            assign sub_s = 1'b0;
        end
        serial_mac_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .sync  (sync_q),
            .a     (a_sr_q[0]),
            .b     (b_q[i]),
            .si    (si_s),
            .sub   (sub_s),
            .so    (so_s[i])
        );
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sync_d   = 1'b0;
        rdy_en_d = 1'b1;
        a_sr_d   = a_sr_q;
        b_d      = b_q;
        sr_d     = sr_q;
        q_d      = q_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    sync_d  = 1'b1;
                    a_sr_d  = a;
                    b_d     = b;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
`ifdef SERIAL_MUL_SIGNED_EN
                a_sr_d = {a_sr_q[W-1], a_sr_q[W-1:1]};
`else
                a_sr_d = {1'b0, a_sr_q[W-1:1]};
`endif
                sr_d = {so_s[0], sr_q[2*W-2:1]};
                // Cell 0's register lags one cycle, so the final bit is taken straight from it.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    q_d     = {so_s[0], sr_q};
                end else if (!sync_q) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sync_q   <= 1'b0;
            rdy_en_q <= 1'b0;
            a_sr_q   <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync_q   <= sync_d;
            rdy_en_q <= rdy_en_d;
            a_sr_q   <= a_sr_d;
            b_q      <= b_d;
            sr_q     <= sr_d;
            q_q      <= q_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && rdy_en_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign q         = q_q;

endmodule

// File: doc/serial_mul_hs.md
SERIAL_MUL_HS -- requirements
Module: serial_mul_hs

Interface
REQ-001 Parameter W, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair a/b present.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  W  multiplicand; serialised LSB first.
REQ-007 b  input  W  multiplier; held in parallel, one bit per cell.
REQ-008 out_valid  output  1  q holds a completed product.
REQ-009 out_ready  input  1  consumer takes q.
REQ-010 q  output  2W  product.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 A transfer is accepted at a rising edge where in_valid and in_ready are both high; a and b are captured on that edge.
REQ-013 FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on accept.
  - RUN to DONE when the bit counter reaches 2W-1.
  - DONE to IDLE on out_ready.
REQ-014 in_ready equals (state == IDLE); there is no overlap of operations.
REQ-015 In RUN, the captured a is shifted out one bit per cycle over exactly 2W cycles, LSB first, zero-extended to 2W bits.
REQ-016 The datapath is a chain of W bit-serial multiply-add cells.
  - Cell i receives b[i] and the serial a bit.
  - Cell W-1 receives sum-in 0.
  - The output of cell 0 is the serial product, LSB first.
REQ-017 Each cell clears its carry/sum flop on a per-operation sync pulse issued in the first RUN cycle.
REQ-018 The serial product is deserialised into a 2W-bit shift register.
  - q is loaded in parallel when the FSM enters DONE.
  - q is held stable while out_valid is high.
REQ-019 Latency: out_valid rises at the (2W+1)th rising edge after the accepting edge, independent of operand values.
REQ-020 q equals a*b modulo 2^(2W), unsigned unless REQ-029 applies.
REQ-021 out_valid stays high with q stable until a rising edge where out_ready is high. That edge returns the FSM to IDLE and clears out_valid.
REQ-022 out_ready is ignored outside DONE, and in_valid is ignored outside IDLE.
REQ-023 in_ready is low in DONE even when out_ready is high. A new operand pair is accepted no earlier than one cycle after the output is taken.
REQ-024 Bit counter width is clog2(2W); it resets to 0 on every accept and never wraps within an operation.

Reset
REQ-025 While rst_n is low, all of the following hold immediately, without waiting for clk:
  - state IDLE, counter 0, shift registers and cell flops 0.
  - q = 0, out_valid = 0, busy = 0.
REQ-026 After rst_n deasserts, in_ready = 1 from the first rising edge onward.
REQ-027 Reset asserted during RUN or DONE abandons the operation. No out_valid pulse follows for that operation.
REQ-028 in_ready is 0 while rst_n is low.

Configuration
REQ-029 Macro SERIAL_MUL_SIGNED_EN controls signed multiplication.
  - When defined, a and b are two's complement.
  - a is sign-extended, not zero-extended, to 2W bits during serialisation.
  - Cell W-1 subtracts its partial product (weight -2^(W-1)).
  - q equals the signed product in 2W-bit two's complement.
REQ-030 When SERIAL_MUL_SIGNED_EN is undefined, operation is unsigned only and no subtract logic is synthesised.
REQ-031 Latency and handshake are identical in both configurations.

Structure
REQ-032 Package serial_mul_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - default width constant DEF_W = 8;
  - a function that returns the counter width for a given W.
REQ-033 Sub-module serial_mac_cell provides one bit-serial multiply-add cell.
  - Ports: clk, rst_n, sync, a, b, si, so; plus sub (tied 0 except cell W-1 when signed).
  - serial_mul_hs instantiates W copies with a generate loop.
REQ-034 Top-level RTL, excluding the package and the cell, is at most 300 lines.

Verification
REQ-035 W=8, unsigned, a=0xFF, b=0xFF, out_ready=1 → q=0xFE01; out_valid at the 17th edge after accept; busy high for 17 cycles.
REQ-036 W=8, a=0x00, b=0xA5, then a=0x0D, b=0x0B back-to-back → q=0x0000, then q=0x008F. in_ready is low throughout each operation and in DONE.
REQ-037 W=8, a=3, b=7, out_ready held low for 10 cycles after out_valid → q=0x0015 stable and out_valid high for all 10 cycles. Clears one edge after out_ready rises.
REQ-038 W=8, rst_n pulsed low at cycle 5 of RUN → outputs zero immediately, no out_valid for that operation. A subsequent a=2, b=2 returns q=0x0004.
REQ-039 SERIAL_MUL_SIGNED_EN defined, W=8, inputs and expected q:
  - a=0x80, b=0x80 → q=0x4000.
  - a=0xFF, b=0x01 → q=0xFFFF.
  - a=0x7F, b=0x80 → q=0xC080.
REQ-040 W=16, unsigned, a=0xFFFF, b=0xFFFF → q=0xFFFE0001; out_valid at the 33rd edge after accept.
